// File: rtl/reg_writeback_arbiter_if.sv
// Bundle of the ALU, long-latency, issue and reg-file write-port signals of the
// write-back arbiter. The arbiter takes the slave view; its environment takes the master view.
interface reg_writeback_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   localparam int NREG = 2 ** ADDR_W;

   logic              i_alu_valid;
   logic [ADDR_W-1:0] i_alu_rd;
   logic [DATA_W-1:0] i_alu_data;
   logic              i_lsu_valid;
   logic              o_lsu_ready;
   logic [ADDR_W-1:0] i_lsu_rd;
   logic [DATA_W-1:0] i_lsu_data;
   logic              i_issue_valid;
   logic [ADDR_W-1:0] i_issue_rd;
   logic              o_reg_write;
   logic [ADDR_W-1:0] o_write_rd;
   logic [DATA_W-1:0] o_write_data;
   logic [NREG-1:0]   o_busy;
   logic              o_alu_stall;
   logic              o_err;

   modport master (
      output i_alu_valid, i_alu_rd, i_alu_data,
      output i_lsu_valid, i_lsu_rd, i_lsu_data,
      output i_issue_valid, i_issue_rd,
      input  o_lsu_ready, o_reg_write, o_write_rd, o_write_data,
      input  o_busy, o_alu_stall, o_err
   );

   modport slave (
      input  i_alu_valid, i_alu_rd, i_alu_data,
      input  i_lsu_valid, i_lsu_rd, i_lsu_data,
      input  i_issue_valid, i_issue_rd,
      output o_lsu_ready, o_reg_write, o_write_rd, o_write_data,
      output o_busy, o_alu_stall, o_err
   );
endinterface

// File: rtl/reg_writeback_arbiter.sv
// Merges ALU results and buffered long-latency results onto the single reg-file
// write port, with starvation control and a busy scoreboard of pending long-latency writes.
module reg_writeback_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 3
) (
   input logic                   i_clk,
   input logic                   i_rst,
   reg_writeback_arbiter_if.slave bus
);
   localparam int NREG  = 2 ** ADDR_W;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
   logic [DATA_W-1:0] data_mem_q [DEPTH];
   logic [PTR_W:0]    wptr_q, rptr_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [NREG-1:0]   busy_q, busy_d;
   logic              we_q;
   logic [ADDR_W-1:0] rd_q;
   logic [DATA_W-1:0] data_q;
   logic              err_q;

   logic              empty, full, stall, alu_req, alu_win, pop, push;
   logic [ADDR_W-1:0] head_rd;
   logic [DATA_W-1:0] head_data;

   assign empty     = (wptr_q == rptr_q);
   assign full      = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                      (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
   assign head_rd   = rd_mem_q[rptr_q[PTR_W-1:0]];
   assign head_data = data_mem_q[rptr_q[PTR_W-1:0]];

   assign stall   = (cnt_q == CNT_W'(STARVE_LIMIT)) && !empty;
   assign alu_req = bus.i_alu_valid && (bus.i_alu_rd != '0);
   // A starved FIFO pre-empts the ALU; otherwise the ALU has priority.
   assign alu_win = alu_req && !stall;
   assign pop     = !empty && !alu_win;
   // Writes to r0 are acknowledged but never buffered.
   assign push    = bus.i_lsu_valid && !full && (bus.i_lsu_rd != '0);

   always_comb begin
      cnt_d = cnt_q;
      if (pop || empty) begin
         cnt_d = '0;
      end else if (alu_win && (cnt_q != CNT_W'(STARVE_LIMIT))) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // A new issue to the same register outranks the retiring write.
   always_comb begin
      busy_d = busy_q;
      if (pop) begin
         busy_d[head_rd] = 1'b0;
      end
      if (bus.i_issue_valid && (bus.i_issue_rd != '0)) begin
         busy_d[bus.i_issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         rd_mem_q[wptr_q[PTR_W-1:0]]   <= bus.i_lsu_rd;
         data_mem_q[wptr_q[PTR_W-1:0]] <= bus.i_lsu_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         busy_q <= '0;
         we_q   <= 1'b0;
         rd_q   <= '0;
         data_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         we_q   <= pop || alu_win;
         if (pop) begin
            rd_q   <= head_rd;
            data_q <= head_data;
         end else if (alu_win) begin
            rd_q   <= bus.i_alu_rd;
            data_q <= bus.i_alu_data;
         end
         err_q <= err_q || (bus.i_alu_valid && stall);
      end
   end

   assign bus.o_lsu_ready  = !full;
   assign bus.o_reg_write  = we_q;
   assign bus.o_write_rd   = rd_q;
   assign bus.o_write_data = data_q;
   assign bus.o_busy       = busy_q;
   assign bus.o_alu_stall  = stall;
   assign bus.o_err        = err_q;
endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Randomised and directed bench for reg_writeback_arbiter; a queue-based reference
// model predicts every write-port cycle and the scoreboard/stall/ready/error state.
module tb_reg_writeback_arbiter;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 4;
   localparam int LIMIT  = 3;

   typedef struct {
      logic              we;
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } wr_t;

   typedef struct {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reg_writeback_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   reg_writeback_arbiter #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   int compared   = 0;
   int mismatched = 0;

   wr_t  exp_q [$];
   ent_t m_fifo [$];
   int   m_cnt;
   logic [31:0] m_busy;
   logic m_err;
   logic [ADDR_W-1:0] m_rd;
   logic [DATA_W-1:0] m_data;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_stall();
      return (m_cnt == LIMIT) && (m_fifo.size() > 0);
   endfunction

   // Reference model: evaluated at each rising edge from the inputs presented.
   task automatic model_update();
      wr_t  w;
      ent_t e;
      bit   was_empty, was_full, areq, awin, do_pop;
      if (rst) begin
         m_fifo.delete();
         m_cnt = 0; m_busy = '0; m_err = 1'b0; m_rd = '0; m_data = '0;
         w.we = 1'b0;
      end else begin
         was_empty = (m_fifo.size() == 0);
         was_full  = (m_fifo.size() == DEPTH);
         areq      = bus.i_alu_valid && (bus.i_alu_rd != 0);
         if (bus.i_alu_valid && m_stall()) m_err = 1'b1;
         do_pop = 0; awin = 0;
         if (m_stall())       do_pop = 1;
         else if (areq)       awin   = 1;
         else if (!was_empty) do_pop = 1;
         w.we = do_pop || awin;
         if (do_pop) begin
            e = m_fifo.pop_front();
            m_busy[e.rd] = 1'b0;
            m_rd = e.rd; m_data = e.data;
         end else if (awin) begin
            m_rd = bus.i_alu_rd; m_data = bus.i_alu_data;
         end
         if (do_pop || was_empty) m_cnt = 0;
         else if (m_cnt < LIMIT)  m_cnt++;
         if (bus.i_lsu_valid && !was_full && bus.i_lsu_rd != 0) begin
            e.rd = bus.i_lsu_rd; e.data = bus.i_lsu_data;
            m_fifo.push_back(e);
         end
         if (bus.i_issue_valid && bus.i_issue_rd != 0) m_busy[bus.i_issue_rd] = 1'b1;
      end
      w.rd = m_rd; w.data = m_data;
      exp_q.push_back(w);
   endtask

   task automatic check_state();
      chk("lsu_ready", 64'(bus.o_lsu_ready), 64'(m_fifo.size() < DEPTH));
      chk("alu_stall", 64'(bus.o_alu_stall), 64'(m_stall()));
      chk("busy",      64'(bus.o_busy),      64'(m_busy));
      chk("err",       64'(bus.o_err),       64'(m_err));
   endtask

   // Write-port monitor: one predicted entry per cycle, including idle cycles.
   always @(negedge clk) begin
      wr_t w;
      if (exp_q.size() > 0) begin
         w = exp_q.pop_front();
         chk("reg_write",  64'(bus.o_reg_write),  64'(w.we));
         chk("write_rd",   64'(bus.o_write_rd),   64'(w.rd));
         chk("write_data", 64'(bus.o_write_data), 64'(w.data));
      end
   end

   task automatic drive(input bit r, input bit av, input int ard, input logic [31:0] ad,
                        input bit lv, input int lrd, input logic [31:0] ld,
                        input bit iv, input int ird);
      rst               = r;
      bus.i_alu_valid   = av;
      bus.i_alu_rd      = ADDR_W'(ard);
      bus.i_alu_data    = ad;
      bus.i_lsu_valid   = lv;
      bus.i_lsu_rd      = ADDR_W'(lrd);
      bus.i_lsu_data    = ld;
      bus.i_issue_valid = iv;
      bus.i_issue_rd    = ADDR_W'(ird);
   endtask

   task automatic tick();
      @(negedge clk);
      check_state();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
         tick();
      end
   endtask

   task automatic do_reset();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // T1: reset with LSU traffic present
      drive(1, 1, 4, 32'h1234, 1, 6, 32'h55, 1, 6);
      @(posedge clk);
      model_update();
      #1;
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("reset_ready", 64'(bus.o_lsu_ready), 64'd1);
      chk("reset_busy",  64'(bus.o_busy),      64'd0);

      // T2: ALU write, then ALU to r0
      drive(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0); tick();
      drive(0, 1, 0, 32'hCAFEF00D, 0, 0, 0, 0, 0); tick();
      idle(2);

      // T3: ordered long-latency retirement
      drive(0, 0, 0, 0, 0, 0, 0, 1, 7); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 9); tick();
      drive(0, 0, 0, 0, 1, 7, 32'h11, 0, 0); tick();
      drive(0, 0, 0, 0, 1, 9, 32'h22, 0, 0); tick();
      idle(3);

      // T5a: starve, ALU backs off on stall
      drive(0, 1, 2, 32'hA0, 1, 12, 32'h77, 1, 12); tick();
      for (int i = 0; i < 8; i++) begin
         drive(0, !m_stall(), 2, 32'hA1 + i, 0, 0, 0, 0, 0);
         tick();
      end
      // T5b: ALU ignores stall
      drive(0, 1, 3, 32'hB0, 1, 13, 32'h88, 0, 0); tick();
      for (int i = 0; i < 6; i++) begin
         drive(0, 1, 3, 32'hB1 + i, 0, 0, 0, 0, 0);
         tick();
      end
      chk("err_sticky", 64'(bus.o_err), 64'd1);
      do_reset();

      // T4: fill the FIFO while the ALU is busy
      for (int i = 0; i < 6; i++) begin
         drive(0, 1, 20 + i, 32'hC0 + i, 1, 1 + i, 32'hD0 + i, 0, 0);
         tick();
      end
      idle(6);
      do_reset();

      // T6: issue and retire the same register at one edge
      drive(0, 0, 0, 0, 1, 3, 32'h33, 1, 3); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 3); tick();
      idle(1);
      chk("busy3_kept", 64'(bus.o_busy[3]), 64'd1);

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         bit av;
         av = ($urandom_range(0, 99) < 55);
         if (m_stall() && $urandom_range(0, 9) != 0) av = 0;
         drive($urandom_range(0, 99) == 0,
               av, $urandom_range(0, 31), $urandom,
               $urandom_range(0, 99) < 45, $urandom_range(0, 31), $urandom,
               $urandom_range(0, 99) < 30, $urandom_range(0, 31));
         tick();
      end
      idle(8);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
